// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular fetch buffer: entries are allocated at request time, filled in order
// as responses return, and popped from the head once filled.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic [63:0]      alloc_pc_i,
  input  logic             fill_i,
  input  logic [31:0]      fill_data_i,
  input  logic             pop_i,
  output logic             head_filled_o,
  output logic [63:0]      head_pc_o,
  output logic [31:0]      head_instr_o,
  output logic [PTR_W:0]   occupancy_o,
  output logic [PTR_W:0]   unfilled_o
);

  fetch_entry_t   entries_q [DEPTH];
  logic [PTR_W:0] tail_q;
  logic [PTR_W:0] fill_q;
  logic [PTR_W:0] head_q;
  fetch_entry_t   headEntry;

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  assign occupancy_o   = tail_q - head_q;
  assign unfilled_o    = tail_q - fill_q;
  assign headEntry     = entries_q[head_q[PTR_W-1:0]];
  assign head_filled_o = (occupancy_o != '0) && headEntry.filled;
  assign head_pc_o     = headEntry.pc;
  assign head_instr_o  = headEntry.instr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tail_q <= '0;
      fill_q <= '0;
      head_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (flush_i) begin
      tail_q <= '0;
      fill_q <= '0;
      head_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i].filled <= 1'b0;
    end else begin
      if (pop_i) head_q <= head_q + 1'b1;
      // Fill, pop and alloc always address distinct entries, so no write conflicts.
      if (fill_i) begin
        entries_q[fill_q[PTR_W-1:0]].instr  <= fill_data_i;
        entries_q[fill_q[PTR_W-1:0]].filled <= 1'b1;
        fill_q <= fill_q + 1'b1;
      end
      if (alloc_i) begin
        entries_q[tail_q[PTR_W-1:0]].pc     <= alloc_pc_i;
        entries_q[tail_q[PTR_W-1:0]].filled <= 1'b0;
        tail_q <= tail_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV64I fetch stage with IF/ID register. Define FETCH_PERF_EN to add the
// FetchCount/BubbleCount performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic        PCSrc_E,
  input  logic [63:0] PCTarget_E,
  output logic [31:0] Instr_D,
  output logic [63:0] PC_D,
  output logic [63:0] PCPlus4_D,
  output logic        Valid_D
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0] FetchCount,
  output logic [63:0] BubbleCount
`endif
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_LIM = (PTR_W+2)'(FIFO_DEPTH);

  logic [63:0]    pcF_q;
  logic [PTR_W:0] dropCnt_q;
  logic [PTR_W:0] dropCnt_d;
  logic [31:0]    instrD_q;
  logic [63:0]    pcD_q;
  logic           validD_q;

  logic [PTR_W:0]   occupancy;
  logic [PTR_W:0]   unfilled;
  logic             headFilled;
  logic [63:0]      headPc;
  logic [31:0]      headInstr;
  logic [PTR_W+1:0] slotsInUse;
  logic [63:0]      targetAligned;
  logic             reqAccept;
  logic             rspCounted;
  logic             rspFill;
  logic             popHead;

  // Pending drops still occupy slots: their responses have yet to arrive.
  assign slotsInUse     = {1'b0, occupancy} + {1'b0, dropCnt_q};
  assign targetAligned  = PCTarget_E & ~64'h3;
  assign imem_req_valid = rst && !PCSrc_E && (slotsInUse < DEPTH_LIM);
  assign imem_req_addr  = pcF_q;
  assign reqAccept      = imem_req_valid && imem_req_ready;
  assign rspCounted     = imem_rsp_valid && ((dropCnt_q != '0) || (unfilled != '0));
  assign rspFill        = imem_rsp_valid && !PCSrc_E && (dropCnt_q == '0) && (unfilled != '0);
  assign popHead        = headFilled && !PCSrc_E && !Flush_D && !Stall_D;

  fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buffer (
    .clk_i         (clk),
    .rst_ni        (rst),
    .flush_i       (PCSrc_E),
    .alloc_i       (reqAccept),
    .alloc_pc_i    (pcF_q),
    .fill_i        (rspFill),
    .fill_data_i   (imem_rsp_data),
    .pop_i         (popHead),
    .head_filled_o (headFilled),
    .head_pc_o     (headPc),
    .head_instr_o  (headInstr),
    .occupancy_o   (occupancy),
    .unfilled_o    (unfilled)
  );

  // On redirect every outstanding response becomes stale, minus one consumed this cycle.
  always_comb begin
    dropCnt_d = dropCnt_q;
    if (PCSrc_E)
      dropCnt_d = dropCnt_q + unfilled - (PTR_W+1)'(rspCounted);
    else if (imem_rsp_valid && (dropCnt_q != '0))
      dropCnt_d = dropCnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcF_q     <= RESET_PC;
      dropCnt_q <= '0;
    end else begin
      dropCnt_q <= dropCnt_d;
      if (PCSrc_E)
        pcF_q <= targetAligned;
      else if (reqAccept)
        pcF_q <= pcF_q + 64'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instrD_q <= NOP_INSTR;
      pcD_q    <= '0;
      validD_q <= 1'b0;
    end else if (PCSrc_E || Flush_D) begin
      instrD_q <= NOP_INSTR;
      validD_q <= 1'b0;
    end else if (!Stall_D) begin
      if (headFilled) begin
        instrD_q <= headInstr;
        pcD_q    <= headPc;
        validD_q <= 1'b1;
      end else begin
        instrD_q <= NOP_INSTR;
        validD_q <= 1'b0;
      end
    end
  end

  assign Instr_D   = instrD_q;
  assign PC_D      = pcD_q;
  assign PCPlus4_D = pcD_q + 64'd4;
  assign Valid_D   = validD_q;

`ifdef FETCH_PERF_EN
  logic [63:0] fetchCnt_q;
  logic [63:0] bubbleCnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else begin
      if (popHead) fetchCnt_q <= fetchCnt_q + 64'd1;
      if (!PCSrc_E && !Flush_D && !Stall_D && !headFilled) bubbleCnt_q <= bubbleCnt_q + 64'd1;
    end
  end

  assign FetchCount  = fetchCnt_q;
  assign BubbleCount = bubbleCnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a random
// phase, all checked against a queue-based fetch model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h1000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqReady = 1'b0;
  logic        rspValid = 1'b0;
  logic [31:0] rspData = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pcSrc = 1'b0;
  logic [63:0] pcTarget = '0;
  logic        reqValid;
  logic [63:0] reqAddr;
  logic [31:0] instrD;
  logic [63:0] pcD;
  logic [63:0] pcPlus4D;
  logic        validD;
`ifdef FETCH_PERF_EN
  logic [63:0] fetchCount;
  logic [63:0] bubbleCount;
`endif

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (reqValid),
    .imem_req_ready (reqReady),
    .imem_req_addr  (reqAddr),
    .imem_rsp_valid (rspValid),
    .imem_rsp_data  (rspData),
    .Stall_D        (stall),
    .Flush_D        (flush),
    .PCSrc_E        (pcSrc),
    .PCTarget_E     (pcTarget),
    .Instr_D        (instrD),
    .PC_D           (pcD),
    .PCPlus4_D      (pcPlus4D),
    .Valid_D        (validD)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount     (fetchCount),
    .BubbleCount    (bubbleCount)
`endif
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  typedef struct { logic [63:0] addr; int due; } memReq_t;
  memReq_t memQ[$];
  int cycle   = 0;
  int lastDue = 0;
  int latMin  = 1;
  int latMax  = 1;

  typedef struct { logic [63:0] pc; bit filled; } mEntry_t;
  mEntry_t     mq[$];
  int          mDrops;
  logic [63:0] mPcF;
  logic        mValid;
  logic [31:0] mInstr;
  logic [63:0] mPcD;
  logic [63:0] mFetch;
  logic [63:0] mBubble;

  logic        lastReqValid;
  logic [63:0] lastReqAddr;
  logic        lastValidD;
  logic [31:0] lastInstrD;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mDrops  = 0;
    mPcF    = RESET_PC;
    mValid  = 1'b0;
    mInstr  = NOP_INSTR;
    mPcD    = '0;
    mFetch  = '0;
    mBubble = '0;
  endtask

  // Advance the fetch model across one clock edge using the current inputs.
  task automatic modelEdge();
    bit expReq;
    bit headReady;
    int unf;
    int firstUnf;
    expReq    = !pcSrc && (mq.size() + mDrops < DEPTH);
    headReady = (mq.size() > 0) && mq[0].filled;
    unf       = 0;
    firstUnf  = -1;
    foreach (mq[i]) if (!mq[i].filled) begin
      unf++;
      if (firstUnf < 0) firstUnf = i;
    end
    if (rspValid) checkOutput("rsp_outstanding", 64'(mDrops + unf > 0), 64'd1);
    if (pcSrc) begin
      mDrops = mDrops + unf - ((rspValid && (mDrops + unf > 0)) ? 1 : 0);
      mq.delete();
      mPcF   = pcTarget & ~64'h3;
      mValid = 1'b0;
      mInstr = NOP_INSTR;
    end else begin
      if (rspValid) begin
        if (mDrops > 0) mDrops--;
        else if (firstUnf >= 0) mq[firstUnf].filled = 1'b1;
      end
      if (flush) begin
        mValid = 1'b0;
        mInstr = NOP_INSTR;
      end else if (!stall) begin
        if (headReady) begin
          mValid = 1'b1;
          mPcD   = mq[0].pc;
          mInstr = memWord(mq[0].pc);
          void'(mq.pop_front());
          mFetch++;
        end else begin
          mValid = 1'b0;
          mInstr = NOP_INSTR;
          mBubble++;
        end
      end
      if (expReq && reqReady) begin
        mq.push_back('{pc: mPcF, filled: 1'b0});
        mPcF = mPcF + 64'd4;
      end
    end
  endtask

  // One clock cycle: check outputs, run memory and model, then drive the next response.
  task automatic step();
    bit expReq;
    int due;
    @(negedge clk);
    expReq = !pcSrc && (mq.size() + mDrops < DEPTH);
    lastReqValid = reqValid;
    lastReqAddr  = reqAddr;
    lastValidD   = validD;
    lastInstrD   = instrD;
    checkOutput("req_valid", 64'(reqValid), 64'(expReq));
    if (expReq) checkOutput("req_addr", reqAddr, mPcF);
    checkOutput("valid_d", 64'(validD), 64'(mValid));
    checkOutput("instr_d", 64'(instrD), 64'(mInstr));
    checkOutput("pc_d", pcD, mPcD);
    checkOutput("pcplus4_d", pcPlus4D, mPcD + 64'd4);
`ifdef FETCH_PERF_EN
    checkOutput("fetch_count", fetchCount, mFetch);
    checkOutput("bubble_count", bubbleCount, mBubble);
`endif
    if (rspValid) void'(memQ.pop_front());
    if (reqValid && reqReady) begin
      due = cycle + int'($urandom_range(latMax, latMin));
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      memQ.push_back('{addr: reqAddr, due: due});
    end
    modelEdge();
    @(posedge clk);
    #1;
    cycle++;
    if (memQ.size() > 0 && memQ[0].due <= cycle) begin
      rspValid = 1'b1;
      rspData  = memWord(memQ[0].addr);
    end else begin
      rspValid = 1'b0;
      rspData  = '0;
    end
  endtask

  task automatic applyReset();
    rst      = 1'b0;
    reqReady = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    pcSrc    = 1'b0;
    pcTarget = '0;
    rspValid = 1'b0;
    rspData  = '0;
    memQ.delete();
    lastDue = 0;
    @(negedge clk);
    checkOutput("rst_valid_d", 64'(validD), 64'd0);
    checkOutput("rst_instr_d", 64'(instrD), 64'(NOP_INSTR));
    checkOutput("rst_pc_d", pcD, 64'd0);
    checkOutput("rst_req_valid", 64'(reqValid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle = 0;
    modelReset();
  endtask

  logic [63:0] firstAddrs [3];
  logic        firstValid [6];

  initial begin
    $display("[TB] fetch_stage bench start");
    @(posedge clk);
    #1;
    applyReset();

    // Sequential fetch from reset with a 1-cycle memory.
    latMin = 1; latMax = 1;
    reqReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c < 3) firstAddrs[c] = lastReqAddr;
      firstValid[c] = lastValidD;
    end
    checkOutput("first_addr0", firstAddrs[0], 64'h1000);
    checkOutput("first_addr1", firstAddrs[1], 64'h1004);
    checkOutput("first_addr2", firstAddrs[2], 64'h1008);
    checkOutput("valid_cycle2", 64'(firstValid[2]), 64'd0);
    checkOutput("valid_cycle3", 64'(firstValid[3]), 64'd1);
    checkOutput("valid_cycle5", 64'(firstValid[5]), 64'd1);

    // Decode stall: buffer fills, requests stop, then resume.
    stall = 1'b1;
    for (int c = 0; c < 5; c++) step();
    checkOutput("stall_req_stopped", 64'(lastReqValid), 64'd0);
    stall = 1'b0;
    for (int c = 0; c < 6; c++) step();

    // Redirect with several responses in flight on a slower memory.
    latMin = 3; latMax = 3;
    for (int c = 0; c < 6; c++) step();
    pcSrc = 1'b1;
    pcTarget = 64'h2002;
    step();
    pcSrc = 1'b0;
    step();
    checkOutput("redirect_req_valid", 64'(lastReqValid), 64'd1);
    checkOutput("redirect_req_addr", lastReqAddr, 64'h2000);
    checkOutput("redirect_valid_d", 64'(lastValidD), 64'd0);
    latMin = 1; latMax = 1;
    for (int c = 0; c < 10; c++) step();

    // Mid-run reset, then ready held low at 0x1008.
    applyReset();
    reqReady = 1'b1;
    step();
    step();
    reqReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("ready_low_addr", lastReqAddr, 64'h1008);
    end
    reqReady = 1'b1;
    step();
    checkOutput("ready_accept_addr", lastReqAddr, 64'h1008);
    step();
    checkOutput("ready_next_addr", lastReqAddr, 64'h100C);
    for (int c = 0; c < 4; c++) step();

    // Flush and stall together load a bubble without popping the head.
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    step();
    checkOutput("flush_stall_valid", 64'(lastValidD), 64'd0);
    checkOutput("flush_stall_instr", 64'(lastInstrD), 64'(NOP_INSTR));
    stall = 1'b0;
    for (int c = 0; c < 6; c++) step();

    // Random traffic with variable latency and random control.
    latMin = 1; latMax = 4;
    for (int c = 0; c < 400; c++) begin
      reqReady = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      pcSrc    = ($urandom_range(0, 24) == 0);
      pcTarget = {$urandom(), $urandom()};
      step();
    end
    pcSrc = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    reqReady = 1'b1;
    for (int c = 0; c < 10; c++) step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
